sha256_msg_padder: RTL and testbench

Front-end initiator for the SHA-256 compression core. Accepts an arbitrary-length message as a byte stream and performs FIPS 180-4 padding: 0x80 marker, zero fill, and a 64-bit big-endian bit length. It feeds 512-bit blocks to the core through its start/init/done handshake, chaining blocks, and returns the final 256-bit digest with a one-cycle valid pulse.

---
 rtl/sha256_msg_padder_if.sv | 26 ++
 rtl/sha256_msg_padder.sv | 169 ++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_padder_if.sv
// Bundles the padder's byte-stream input and the compression-core handshake.
// The master modport is the padder side; slave is the upstream source plus core.
interface sha256_msg_padder_if;
   logic         i_Valid;
   logic [7:0]   i_Data;
   logic         i_Keep;
   logic         i_Last;
   logic         o_Ready;
   logic         o_fStart;
   logic         o_fInit;
   logic [511:0] o_Block;
   logic         i_fDone;
   logic [255:0] i_Digest;
   logic         o_fDigestValid;
   logic [255:0] o_Digest;

   modport master (
      input  i_Valid, i_Data, i_Keep, i_Last, i_fDone, i_Digest,
      output o_Ready, o_fStart, o_fInit, o_Block, o_fDigestValid, o_Digest
   );

   modport slave (
      output i_Valid, i_Data, i_Keep, i_Last, i_fDone, i_Digest,
      input  o_Ready, o_fStart, o_fInit, o_Block, o_fDigestValid, o_Digest
   );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a byte stream into padded 512-bit blocks,
// drives the compression core block by block and returns the final digest.
module sha256_msg_padder #(
   parameter int CNT_W = 32
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst,
   sha256_msg_padder_if.master  bus
);

   typedef enum logic [2:0] {FILL, PAD, SEND, WAIT, LEN} state_t;

   state_t             state_q, state_d;
   logic [511:0]       buf_q, buf_d;
   logic [6:0]         pos_q, pos_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               first_q, first_d;
   logic               final_q, final_d;
   logic               need_len_q, need_len_d;
   logic               pend_q, pend_d;
   logic               ready_q, ready_d;
   logic               start_q, start_d;
   logic               init_q, init_d;
   logic               dvalid_q, dvalid_d;
   logic [255:0]       digest_q, digest_d;

   logic               accept;
   logic [63:0]        len64;
   logic [8:0]         base;

   assign accept = bus.i_Valid && ready_q;
   assign len64  = 64'({cnt_q, 3'b000});
   assign base   = 9'd504 - {pos_q[5:0], 3'b000};

   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      pos_d      = pos_q;
      cnt_d      = cnt_q;
      first_d    = first_q;
      final_d    = final_q;
      need_len_d = need_len_q;
      pend_d     = pend_q;
      digest_d   = digest_q;
      dvalid_d   = 1'b0;

      case (state_q)
         FILL: begin
            if (accept) begin
               if (bus.i_Keep) begin
                  buf_d[base +: 8] = bus.i_Data;
                  pos_d            = pos_q + 7'd1;
                  cnt_d            = cnt_q + CNT_W'(1);
               end
               if (bus.i_Last) begin
                  state_d = PAD;
               end else if (bus.i_Keep && pos_q == 7'd63) begin
                  state_d = SEND;
               end
            end
         end

         PAD: begin
            // A full block defers the 0x80 marker to the separate length block.
            if (pos_q == 7'd64) begin
               need_len_d = 1'b1;
               pend_d     = 1'b1;
            end else begin
               for (int i = 0; i < 64; i++) begin
                  if (7'(i) == pos_q) begin
                     buf_d[511-8*i -: 8] = 8'h80;
                  end else if (7'(i) > pos_q) begin
                     buf_d[511-8*i -: 8] = 8'h00;
                  end
               end
               if (pos_q <= 7'd55) begin
                  buf_d[63:0] = len64;
                  final_d     = 1'b1;
               end else begin
                  need_len_d = 1'b1;
                  pend_d     = 1'b0;
               end
            end
            state_d = SEND;
         end

         SEND: begin
            first_d = 1'b0;
            state_d = WAIT;
         end

         WAIT: begin
            if (bus.i_fDone) begin
               if (final_q) begin
                  digest_d = bus.i_Digest;
                  dvalid_d = 1'b1;
                  pos_d    = 7'd0;
                  cnt_d    = '0;
                  first_d  = 1'b1;
                  final_d  = 1'b0;
                  buf_d    = '0;
                  state_d  = FILL;
               end else if (need_len_q) begin
                  state_d = LEN;
               end else begin
                  buf_d   = '0;
                  pos_d   = 7'd0;
                  state_d = FILL;
               end
            end
         end

         LEN: begin
            buf_d      = {(pend_q ? 8'h80 : 8'h00), 440'd0, len64};
            final_d    = 1'b1;
            need_len_d = 1'b0;
            pend_d     = 1'b0;
            state_d    = SEND;
         end

         default: state_d = FILL;
      endcase

      // Outputs are decoded from the next state so they align with that state.
      ready_d = (state_d == FILL);
      start_d = (state_d == SEND);
      init_d  = (state_d == SEND) && first_q;
   end

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state_q    <= FILL;
         buf_q      <= '0;
         pos_q      <= 7'd0;
         cnt_q      <= '0;
         first_q    <= 1'b1;
         final_q    <= 1'b0;
         need_len_q <= 1'b0;
         pend_q     <= 1'b0;
         ready_q    <= 1'b1;
         start_q    <= 1'b0;
         init_q     <= 1'b0;
         dvalid_q   <= 1'b0;
         digest_q   <= '0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         pos_q      <= pos_d;
         cnt_q      <= cnt_d;
         first_q    <= first_d;
         final_q    <= final_d;
         need_len_q <= need_len_d;
         pend_q     <= pend_d;
         ready_q    <= ready_d;
         start_q    <= start_d;
         init_q     <= init_d;
         dvalid_q   <= dvalid_d;
         digest_q   <= digest_d;
      end
   end

   assign bus.o_Ready        = ready_q;
   assign bus.o_fStart       = start_q;
   assign bus.o_fInit        = init_q;
   assign bus.o_Block        = buf_q;
   assign bus.o_fDigestValid = dvalid_q;
   assign bus.o_Digest       = digest_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: a behavioural SHA-256 core answers each start,
// and a scoreboard of expected blocks and digests is filled as messages are driven.
module tb_sha256_msg_padder;

   typedef struct {
      logic [511:0] blk;
      logic         init;
   } blk_exp_t;

   localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] DIG56     = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'd0, 64'h18};
   localparam logic [511:0] EMPTY_BLK = {8'h80, 504'd0};
   localparam logic [511:0] LEN56_BLK = {448'd0, 64'h1c0};
   localparam logic [511:0] LEN64_BLK = {8'h80, 440'd0, 64'h200};

   logic [31:0] k_tab [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic clk;
   logic rst_n;
   sha256_msg_padder_if bus ();

   sha256_msg_padder #(.CNT_W(32)) dut (
      .i_Clk (clk),
      .i_Rst (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int           n_vec = 0;
   int           n_miss = 0;
   int           n_starts = 0;
   int           n_dv = 0;
   blk_exp_t     exp_q[$];
   logic [255:0] dig_q[$];
   logic [7:0]   msg_q[$];
   logic [511:0] last_blk = '0;
   logic         last_init = 1'b0;
   logic [255:0] last_digest = '0;

   task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] shaCompress(input logic [255:0] h_in, input logic [511:0] blk);
      logic [31:0] w [0:63];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
      for (int i = 16; i < 64; i++)
         w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
              + w[i-7]  + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
      {a, b, c, d, e, f, g, h} = h_in;
      for (int i = 0; i < 64; i++) begin
         t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k_tab[i] + w[i];
         t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1;
         d = c; c = b; b = a; a = t1 + t2;
      end
      return {h_in[255:224] + a, h_in[223:192] + b, h_in[191:160] + c, h_in[159:128] + d,
              h_in[127:96]  + e, h_in[95:64]    + f, h_in[63:32]    + g, h_in[31:0]     + h};
   endfunction

   task automatic loadMsg(input string s);
      msg_q.delete();
      for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
   endtask

   // Pads the message independently, queues expected blocks/digest, then drives beats.
   task automatic applyStimulus(input bit hold_valid);
      logic [7:0]   pad[$];
      logic [63:0]  bitlen;
      logic [511:0] blk;
      logic [255:0] h;
      int           n, nbeats, guard;
      blk_exp_t     e;
      n      = msg_q.size();
      bitlen = 64'(n) * 64'd8;
      pad    = msg_q;
      pad.push_back(8'h80);
      while (pad.size() % 64 != 56) pad.push_back(8'h00);
      for (int i = 7; i >= 0; i--) pad.push_back(bitlen[8*i +: 8]);
      h = IV;
      for (int b = 0; b < pad.size() / 64; b++) begin
         for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = pad[b*64 + i];
         e.blk  = blk;
         e.init = (b == 0);
         exp_q.push_back(e);
         h = shaCompress((b == 0) ? IV : h, blk);
      end
      dig_q.push_back(h);

      nbeats = (n == 0) ? 1 : n;
      for (int i = 0; i < nbeats; i++) begin
         bus.i_Valid = 1'b1;
         bus.i_Data  = (n == 0) ? 8'h00 : msg_q[i];
         bus.i_Keep  = (n != 0);
         bus.i_Last  = (i == nbeats - 1);
         guard = 0;
         while (!bus.o_Ready && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
         end
         if (guard >= 2000) begin
            checkOutput("ready_timeout", 512'd0, 512'd1);
            break;
         end
         @(posedge clk); #1;
      end
      if (!hold_valid) bus.i_Valid = 1'b0;
   endtask

   task automatic waitStarts(input int target, input string tag);
      int g = 0;
      while (n_starts < target && g < 1000) begin
         @(posedge clk); #1;
         g++;
      end
      checkOutput(tag, 512'(n_starts), 512'(target));
   endtask

   task automatic waitDigests(input int target, input string tag);
      int g = 0;
      while (n_dv < target && g < 2000) begin
         @(posedge clk); #1;
         g++;
      end
      checkOutput(tag, 512'(n_dv), 512'(target));
   endtask

   // Behavioural compression core: answers each start 66 cycles later.
   initial begin : core_model
      logic [255:0] h_state;
      logic [255:0] dig;
      logic [511:0] cap_blk;
      logic         cap_init;
      bit           aborted;
      blk_exp_t     e;
      bus.i_fDone  = 1'b0;
      bus.i_Digest = '0;
      h_state      = IV;
      forever begin
         @(posedge clk); #1;
         if (rst_n && bus.o_fStart) begin
            n_starts++;
            cap_blk   = bus.o_Block;
            cap_init  = bus.o_fInit;
            last_blk  = cap_blk;
            last_init = cap_init;
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_start", 512'd1, 512'd0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("block", cap_blk, e.blk);
               checkOutput("init", 512'(cap_init), 512'(e.init));
            end
            dig     = shaCompress(cap_init ? IV : h_state, cap_blk);
            h_state = dig;
            aborted = 1'b0;
            for (int c = 0; c < 66; c++) begin
               @(posedge clk); #1;
               if (!rst_n) begin
                  aborted = 1'b1;
                  break;
               end
            end
            if (!aborted) begin
               checkOutput("block_stable", bus.o_Block, cap_blk);
               bus.i_fDone  = 1'b1;
               bus.i_Digest = dig;
               @(posedge clk); #1;
               bus.i_fDone  = 1'b0;
               bus.i_Digest = '0;
            end
         end
      end
   end

   initial begin : digest_monitor
      logic [255:0] exp_d;
      forever begin
         @(posedge clk); #1;
         if (rst_n && bus.o_fDigestValid) begin
            n_dv++;
            last_digest = bus.o_Digest;
            if (dig_q.size() == 0) begin
               checkOutput("unexpected_digest", 512'd1, 512'd0);
            end else begin
               exp_d = dig_q.pop_front();
               checkOutput("digest", 512'(bus.o_Digest), 512'(exp_d));
            end
            @(posedge clk); #1;
            checkOutput("dvalid_pulse", 512'(bus.o_fDigestValid), 512'd0);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int s0, d0;
      rst_n       = 1'b0;
      bus.i_Valid = 1'b0;
      bus.i_Data  = 8'h00;
      bus.i_Keep  = 1'b0;
      bus.i_Last  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ready",  512'(bus.o_Ready), 512'd1);
      checkOutput("rst_start",  512'(bus.o_fStart), 512'd0);
      checkOutput("rst_init",   512'(bus.o_fInit), 512'd0);
      checkOutput("rst_block",  bus.o_Block, 512'd0);
      checkOutput("rst_dvalid", 512'(bus.o_fDigestValid), 512'd0);
      checkOutput("rst_digest", 512'(bus.o_Digest), 512'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      $display("[TB] message abc");
      loadMsg("abc");
      s0 = n_starts; d0 = n_dv;
      applyStimulus(1'b0);
      waitDigests(d0 + 1, "abc_done");
      checkOutput("abc_starts", 512'(n_starts - s0), 512'd1);
      checkOutput("abc_block", last_blk, ABC_BLK);
      checkOutput("abc_init", 512'(last_init), 512'd1);
      checkOutput("abc_digest", 512'(last_digest), 512'(ABC_DIG));

      $display("[TB] empty message");
      loadMsg("");
      s0 = n_starts; d0 = n_dv;
      applyStimulus(1'b0);
      waitDigests(d0 + 1, "empty_done");
      checkOutput("empty_starts", 512'(n_starts - s0), 512'd1);
      checkOutput("empty_block", last_blk, EMPTY_BLK);
      checkOutput("empty_digest", 512'(last_digest), 512'(EMPTY_DIG));

      $display("[TB] 56-byte message");
      loadMsg("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
      s0 = n_starts; d0 = n_dv;
      applyStimulus(1'b0);
      waitDigests(d0 + 1, "m56_done");
      checkOutput("m56_starts", 512'(n_starts - s0), 512'd2);
      checkOutput("m56_len_block", last_blk, LEN56_BLK);
      checkOutput("m56_init2", 512'(last_init), 512'd0);
      checkOutput("m56_digest", 512'(last_digest), 512'(DIG56));

      $display("[TB] 64-byte message");
      msg_q.delete();
      for (int i = 0; i < 64; i++) msg_q.push_back(8'(i * 3 + 1));
      s0 = n_starts; d0 = n_dv;
      applyStimulus(1'b0);
      waitStarts(s0 + 1, "m64_first_start");
      repeat (5) @(posedge clk);
      #1;
      checkOutput("m64_ready_in_wait", 512'(bus.o_Ready), 512'd0);
      waitDigests(d0 + 1, "m64_done");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("m64_starts", 512'(n_starts - s0), 512'd2);
      checkOutput("m64_len_block", last_blk, LEN64_BLK);

      $display("[TB] back-to-back abc then empty");
      s0 = n_starts; d0 = n_dv;
      loadMsg("abc");
      applyStimulus(1'b1);
      loadMsg("");
      applyStimulus(1'b0);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("b2b_digest_hold", 512'(bus.o_Digest), 512'(ABC_DIG));
      waitDigests(d0 + 2, "b2b_done");
      checkOutput("b2b_init", 512'(last_init), 512'd1);
      checkOutput("b2b_digest2", 512'(last_digest), 512'(EMPTY_DIG));

      $display("[TB] reset during WAIT");
      loadMsg("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
      s0 = n_starts;
      applyStimulus(1'b0);
      waitStarts(s0 + 1, "abort_first_start");
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_ready",  512'(bus.o_Ready), 512'd1);
      checkOutput("abort_start",  512'(bus.o_fStart), 512'd0);
      checkOutput("abort_block",  bus.o_Block, 512'd0);
      checkOutput("abort_dvalid", 512'(bus.o_fDigestValid), 512'd0);
      checkOutput("abort_digest", 512'(bus.o_Digest), 512'd0);
      repeat (3) @(posedge clk);
      #1;
      exp_q.delete();
      dig_q.delete();
      rst_n = 1'b1;
      @(posedge clk); #1;
      loadMsg("abc");
      s0 = n_starts; d0 = n_dv;
      applyStimulus(1'b0);
      waitDigests(d0 + 1, "post_abort_done");
      checkOutput("post_abort_starts", 512'(n_starts - s0), 512'd1);
      checkOutput("post_abort_digest", 512'(last_digest), 512'(ABC_DIG));

      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
